puf_xl_mc: RTL

Multi-channel PUF readout controller: sequences NCH external PUF cores, fetches a burst of response words from a selected core, and buffers them in an internal FIFO. It is driven through the standard control/address/data_in/data_out/end_op accelerator bus. It sits between the SoC bus bridge and the PUF core instances, replacing the single-core direct-mapped wrapper with a command-driven, buffered, multi-channel front end.

---
 rtl/puf_xl_mc.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/puf_xl_mc.sv
`default_nettype none
// ============================================================================
// Module   : puf_xl_mc
// Desc     : Multi-channel PUF readout controller. Takes read/pop commands
//            from the accelerator bus, starts one of NCH PUF cores per word,
//            and buffers the returned response words in an internal FIFO.
// Ports    : clk, i_rst (async, active low)
//            control  - [0] soft clear, [1] start/pop strobe, [3:2] op
//            address  - [AW-1:0] start addr, [47:32] length, [51:48] channel
//            data_in  - reserved
//            data_out - popped word and live status fields
//            end_op   - sticky operation-complete flag
//            core_rst/core_str/core_addr/core_end/core_out - PUF core side
// Config   : define PUF_XL_MC_TIMEOUT_EN to enable the WAIT-state watchdog
// Revision : 1.0 - initial release
// ============================================================================
module puf_xl_mc #(
    parameter int NCH        = 2,
    parameter int DBW        = 32,
    parameter int AW         = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int TO_W       = 20
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [31:0]          control,
    input  logic [63:0]          address,
    input  logic [63:0]          data_in,
    output logic [63:0]          data_out,
    output logic                 end_op,
    output logic [NCH-1:0]       core_rst,
    output logic [NCH-1:0]       core_str,
    output logic [AW-1:0]        core_addr,
    input  logic [NCH-1:0]       core_end,
    input  logic [NCH*DBW-1:0]   core_out
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] C_S_IDLE = 3'd0;
    localparam logic [2:0] C_S_ARM  = 3'd1;
    localparam logic [2:0] C_S_WAIT = 3'd2;
    localparam logic [2:0] C_S_CAPT = 3'd3;
    localparam logic [2:0] C_S_DONE = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_strb_prev;
    logic [3:0]           r_ch;
    logic [AW-1:0]        r_addr;
    logic [15:0]          r_rem;
    logic                 r_end_op;
    logic                 r_to_err;
    logic                 r_ch_err;
    logic [DBW-1:0]       r_mem [FIFO_DEPTH];
    logic [C_PTR_W:0]     r_wptr;
    logic [C_PTR_W:0]     r_rptr;
    logic [DBW-1:0]       r_pop_word;
    logic [15:0]          r_stat_rem;
    logic [7:0]           r_stat_lvl;
    logic                 r_stat_busy;
    logic                 r_stat_to;
    logic                 r_stat_cherr;
    logic                 r_stat_empty;
    logic                 r_stat_full;

    logic                 w_clr;
    logic                 w_evt;
    logic [1:0]           w_op;
    logic                 w_rd_evt;
    logic                 w_pop_evt;
    logic                 w_pop;
    logic                 w_push;
    logic [3:0]           w_ch;
    logic [15:0]          w_len;
    logic                 w_ch_bad;
    logic [C_PTR_W:0]     w_level;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_busy;
    logic [15:0]          w_end_pad;
    logic                 w_end_sel;
    logic [DBW-1:0]       w_core_word;
    logic [31:0]          w_pop_ext;
    logic                 w_wd_expire;
    logic                 w_unused_bits;

    // Command decode; soft clear masks every event in the same cycle.
    assign w_clr     = control[0];
    assign w_evt     = control[1] & ~r_strb_prev;
    assign w_op      = control[3:2];
    assign w_rd_evt  = w_evt & ~w_clr & ((w_op == 2'b01) | (w_op == 2'b10));
    assign w_pop_evt = w_evt & ~w_clr & (w_op == 2'b11);
    assign w_ch      = address[51:48];
    assign w_len     = (w_op == 2'b01) ? 16'd1 : address[47:32];
    assign w_ch_bad  = ({28'd0, w_ch} >= 32'(NCH));

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_PTR_W-1:0] == r_rptr[C_PTR_W-1:0]) &&
                     (r_wptr[C_PTR_W] != r_rptr[C_PTR_W]);
    assign w_pop   = w_pop_evt & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = (r_state == C_S_CAPT) & ~w_clr & (~w_full | w_pop);
    assign w_busy  = (r_state == C_S_ARM) | (r_state == C_S_WAIT) |
                     (r_state == C_S_CAPT);

    // Zero-padded so an out-of-range channel index never selects past NCH.
    assign w_end_pad = 16'(core_end);
    assign w_end_sel = w_end_pad[r_ch];

    always_comb begin
        w_core_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ch == 4'(k)) begin
                w_core_word = core_out[k*DBW +: DBW];
            end
        end
    end

    // Core-side outputs are decoded straight from the flops so a reset
    // drops the start pulse immediately.
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_core_str
            assign core_str[g] = (r_state == C_S_ARM) && (r_ch == 4'(g));
        end
    endgenerate

    assign core_rst  = {NCH{control[0]}};
    assign core_addr = r_addr;

`ifdef PUF_XL_MC_TIMEOUT_EN
    logic [TO_W-1:0] r_wd;

    // Abort on the WAIT cycle in which the counter would reach all-ones.
    assign w_wd_expire = (r_state == C_S_WAIT) && !w_end_sel &&
                         (&r_wd[TO_W-1:1]) && !r_wd[0];

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wd <= '0;
        end else if (r_state != C_S_WAIT) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    logic [TO_W-1:0] w_unused_wd;

    assign w_unused_wd = '0;
    assign w_wd_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_S_IDLE: begin
                if (w_rd_evt) begin
                    w_state_nxt = ((w_len == 16'd0) || w_ch_bad) ? C_S_DONE : C_S_ARM;
                end
            end
            C_S_ARM:  w_state_nxt = C_S_WAIT;
            C_S_WAIT: begin
                if (w_end_sel) begin
                    w_state_nxt = C_S_CAPT;
                end else if (w_wd_expire) begin
                    w_state_nxt = C_S_DONE;
                end
            end
            C_S_CAPT: begin
                if (w_push) begin
                    w_state_nxt = (r_rem == 16'd1) ? C_S_DONE : C_S_ARM;
                end
            end
            C_S_DONE: w_state_nxt = C_S_IDLE;
            default:  w_state_nxt = C_S_IDLE;
        endcase
        if (w_clr) begin
            w_state_nxt = C_S_IDLE;
        end
    end

    // Command, pointer and flag registers
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_strb_prev <= 1'b0;
            r_ch        <= '0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_end_op    <= 1'b0;
            r_to_err    <= 1'b0;
            r_ch_err    <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_pop_word  <= '0;
        end else begin
            r_strb_prev <= control[1];
            if (w_clr) begin
                r_rem      <= '0;
                r_end_op   <= 1'b0;
                r_to_err   <= 1'b0;
                r_ch_err   <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_pop_word <= '0;
            end else begin
                if ((r_state == C_S_IDLE) && w_rd_evt) begin
                    r_ch     <= w_ch;
                    r_addr   <= address[AW-1:0];
                    r_rem    <= w_len;
                    r_end_op <= 1'b0;
                    r_to_err <= 1'b0;
                    r_ch_err <= w_ch_bad;
                end
                if (r_state == C_S_DONE) begin
                    r_end_op <= 1'b1;
                end
                if (w_wd_expire) begin
                    r_to_err <= 1'b1;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                    r_addr <= r_addr + 1'b1;
                    r_rem  <= r_rem - 1'b1;
                end
                if (w_pop) begin
                    r_rptr     <= r_rptr + 1'b1;
                    r_pop_word <= r_mem[r_rptr[C_PTR_W-1:0]];
                end
            end
        end
    end

    // FIFO storage; a flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[C_PTR_W-1:0]] <= w_core_word;
        end
    end

    // Status fields trail the internal state by one cycle.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stat_rem   <= '0;
            r_stat_lvl   <= '0;
            r_stat_busy  <= 1'b0;
            r_stat_to    <= 1'b0;
            r_stat_cherr <= 1'b0;
            r_stat_empty <= 1'b1;
            r_stat_full  <= 1'b0;
        end else begin
            r_stat_rem   <= r_rem;
            r_stat_lvl   <= 8'(w_level);
            r_stat_busy  <= w_busy;
            r_stat_to    <= r_to_err;
            r_stat_cherr <= r_ch_err;
            r_stat_empty <= w_empty;
            r_stat_full  <= w_full;
        end
    end

    assign w_pop_ext = 32'(r_pop_word);
    assign data_out  = {3'b000, r_stat_full, r_stat_empty, r_stat_cherr, r_stat_to,
                        r_stat_busy, r_stat_lvl, r_stat_rem, w_pop_ext};
    assign end_op    = r_end_op;

    assign w_unused_bits = ^{data_in, control[31:4], address[63:52], address[31:AW]};

endmodule
`default_nettype wire
